// File: rtl/noc_pkg.sv
// Shared definitions for the PE injection bridge: mesh size defaults, PE id type
// and the flit packing helper.
package noc_pkg;

    localparam int NOC_ROWS_DEF = 3;
    localparam int NOC_COLS_DEF = 3;

    // Wide enough to hold the PE index of the default 3x3 mesh.
    localparam int PE_ID_W = 4;
    typedef logic [PE_ID_W-1:0] pe_id_t;

    // The caller narrows the result to its own flit width.
    localparam int FLIT_PACK_W = 128;

    function automatic logic [FLIT_PACK_W-1:0] flit_pack(
        input logic [FLIT_PACK_W-1:0] src,
        input logic [FLIT_PACK_W-1:0] data,
        input int unsigned            data_w
    );
        return (src << data_w) | data;
    endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Single-clock FIFO with count-based full/empty and synchronous active-low reset.
// DEPTH must be a power of two so the pointers wrap naturally.
module noc_sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    // A push onto a full FIFO is only taken when the same cycle frees a slot.
    assign do_push  = push & (~full | pop);
    assign do_pop   = pop & ~empty;
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/noc_pe_inject_bridge.sv
// PE-side injection bridge: per-PE FIFOs merged round-robin onto one source-tagged
// flit stream. Optional per-PE grant counters under NOC_PE_INJECT_BRIDGE_STATS_EN.
module noc_pe_inject_bridge
    import noc_pkg::*;
#(
    parameter int ROWS   = NOC_ROWS_DEF,
    parameter int COLS   = NOC_COLS_DEF,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
`ifdef NOC_PE_INJECT_BRIDGE_STATS_EN
    parameter int CNT_W  = 16,
`endif
    localparam int N_PE   = ROWS * COLS,
    localparam int SRC_W  = (N_PE > 1) ? $clog2(N_PE) : 1,
    localparam int FLIT_W = SRC_W + DATA_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [N_PE*DATA_W-1:0]   pe_in_data,
    input  logic [N_PE-1:0]          pe_in_valid,
    output logic [N_PE-1:0]          pe_in_ready,
    output logic [FLIT_W-1:0]        flit_out_data,
    output logic                     flit_out_valid,
    input  logic                     flit_out_ready,
    output logic [N_PE-1:0]          fifo_full
`ifdef NOC_PE_INJECT_BRIDGE_STATS_EN
    ,
    input  logic [SRC_W-1:0]         stat_sel,
    output logic [CNT_W-1:0]         stat_count
`endif
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
    // Ready never looks at valid; a valid flit holds data stable until it transfers.

    logic [N_PE-1:0]   fifo_push;
    logic [N_PE-1:0]   fifo_pop;
    logic [N_PE-1:0]   fifo_empty;
    logic [DATA_W-1:0] fifo_dout [N_PE];

    logic [SRC_W-1:0]  rr_ptr;
    logic [SRC_W-1:0]  grant_idx;
    logic [SRC_W-1:0]  cand_idx;
    logic              grant_found;
    logic              load;
    logic [DATA_W-1:0] head_data;

    assign pe_in_ready = {N_PE{reset & enable}} & ~fifo_full;
    assign fifo_push   = pe_in_valid & pe_in_ready;

    genvar g;
    generate
        for (g = 0; g < N_PE; g++) begin : g_pe
            noc_sync_fifo #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH)
            ) u_fifo (
                .clock     (clock),
                .reset     (reset),
                .push      (fifo_push[g]),
                .push_data (pe_in_data[g*DATA_W +: DATA_W]),
                .pop       (fifo_pop[g]),
                .pop_data  (fifo_dout[g]),
                .full      (fifo_full[g]),
                .empty     (fifo_empty[g])
            );
            assign fifo_pop[g] = load & (grant_idx == SRC_W'(g));
        end
    endgenerate

    // First non-empty FIFO at or after rr_ptr, wrapping past the last PE.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int k = 0; k < N_PE; k++) begin
            cand_idx = SRC_W'((int'(rr_ptr) + k) % N_PE);
            if (!grant_found && !fifo_empty[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        head_data = '0;
        for (int i = 0; i < N_PE; i++) begin
            if (grant_idx == SRC_W'(i)) head_data = fifo_dout[i];
        end
    end

    assign load = enable & grant_found & (~flit_out_valid | flit_out_ready);

    always_ff @(posedge clock) begin
        if (!reset) begin
            flit_out_valid <= 1'b0;
            flit_out_data  <= '0;
            rr_ptr         <= '0;
        end else if (load) begin
            flit_out_valid <= 1'b1;
            flit_out_data  <= FLIT_W'(flit_pack(FLIT_PACK_W'(grant_idx),
                                                FLIT_PACK_W'(head_data),
                                                DATA_W));
            rr_ptr         <= (grant_idx == SRC_W'(N_PE - 1)) ? '0 : grant_idx + 1'b1;
        end else if (flit_out_ready) begin
            flit_out_valid <= 1'b0;
        end
    end

`ifdef NOC_PE_INJECT_BRIDGE_STATS_EN
    logic [CNT_W-1:0] grant_cnt [N_PE];

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < N_PE; i++) grant_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_PE; i++) begin
                if (fifo_pop[i] && (grant_cnt[i] != '1)) grant_cnt[i] <= grant_cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        stat_count = '0;
        for (int i = 0; i < N_PE; i++) begin
            if (stat_sel == SRC_W'(i)) stat_count = grant_cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_noc_pe_inject_bridge.sv
// Self-checking bench for noc_pe_inject_bridge: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_noc_pe_inject_bridge;

    localparam int ROWS   = 3;
    localparam int COLS   = 3;
    localparam int N_PE   = ROWS * COLS;
    localparam int DW     = 32;
    localparam int DEPTH  = 4;
    localparam int SRC_W  = 4;
    localparam int FLIT_W = SRC_W + DW;

    logic                 clock;
    logic                 reset;
    logic                 enable;
    logic [N_PE*DW-1:0]   pe_in_data;
    logic [N_PE-1:0]      pe_in_valid;
    logic [N_PE-1:0]      pe_in_ready;
    logic [FLIT_W-1:0]    flit_out_data;
    logic                 flit_out_valid;
    logic                 flit_out_ready;
    logic [N_PE-1:0]      fifo_full;
`ifdef NOC_PE_INJECT_BRIDGE_STATS_EN
    logic [SRC_W-1:0]     stat_sel;
    logic [15:0]          stat_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [FLIT_W-1:0] exp_q[$];

    noc_pe_inject_bridge #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .DATA_W (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .pe_in_data     (pe_in_data),
        .pe_in_valid    (pe_in_valid),
        .pe_in_ready    (pe_in_ready),
        .flit_out_data  (flit_out_data),
        .flit_out_valid (flit_out_valid),
        .flit_out_ready (flit_out_ready),
        .fifo_full      (fifo_full)
`ifdef NOC_PE_INJECT_BRIDGE_STATS_EN
        ,
        .stat_sel       (stat_sel),
        .stat_count     (stat_count)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    // Per-PE queues of words, an output slot and a round-robin start index.
    logic [DW-1:0]     mq [N_PE][$];
    int                m_rr;
    int                m_g;
    logic              m_valid;
    logic [FLIT_W-1:0] m_data;
    logic [N_PE-1:0]   m_rdy;
    logic [DW-1:0]     m_word;
    logic [SRC_W-1:0]  m_src;

    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < N_PE; i++) mq[i].delete();
            m_rr    = 0;
            m_valid = 1'b0;
            m_data  = '0;
        end else begin
            m_g = -1;
            for (int i = 0; i < N_PE; i++) m_rdy[i] = enable && (mq[i].size() < DEPTH);
            if (enable && (!m_valid || flit_out_ready)) begin
                for (int k = 0; k < N_PE; k++) begin
                    if (m_g < 0 && mq[(m_rr + k) % N_PE].size() > 0) m_g = (m_rr + k) % N_PE;
                end
            end
            if (m_g >= 0) begin
                m_word  = mq[m_g].pop_front();
                m_src   = m_g[SRC_W-1:0];
                m_data  = {m_src, m_word};
                m_valid = 1'b1;
                m_rr    = (m_g + 1) % N_PE;
            end else if (flit_out_ready) begin
                m_valid = 1'b0;
            end
            for (int i = 0; i < N_PE; i++) begin
                if (pe_in_valid[i] && m_rdy[i]) mq[i].push_back(pe_in_data[i*DW +: DW]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        enable         = 1'b0;
        pe_in_valid    = '0;
        flit_out_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset          = 1'b0;
        enable         = 1'b1;
        pe_in_valid    = '1;
        pe_in_data     = '1;
        flit_out_ready = 1'b1;
        repeat (3) tick();
        n_tests++;
        if (flit_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", flit_out_valid); end
        n_tests++;
        if (flit_out_data !== '0) begin n_fail++; $display("FAIL reset_data got %h exp 0", flit_out_data); end
        n_tests++;
        if (fifo_full !== '0) begin n_fail++; $display("FAIL reset_full got %b exp 0", fifo_full); end
        n_tests++;
        if (pe_in_ready !== '0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", pe_in_ready); end
        pe_in_valid = '0;
        reset = 1'b1;
        #1;
        n_tests++;
        if (pe_in_ready !== '1) begin n_fail++; $display("FAIL ready_after_reset got %b exp 1ff", pe_in_ready); end
    endtask

    task automatic test_single();
        logic [FLIT_W-1:0] exp;
        exp = {4'd4, 32'hDEADBEEF};
        do_reset();
        enable         = 1'b1;
        flit_out_ready = 1'b1;
        pe_in_valid[4] = 1'b1;
        pe_in_data[4*DW +: DW] = 32'hDEADBEEF;
        #1;
        n_tests++;
        if (pe_in_ready[4] !== 1'b1) begin n_fail++; $display("FAIL single_ready got %b exp 1", pe_in_ready[4]); end
        tick();
        pe_in_valid = '0;
        n_tests++;
        if (flit_out_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass got %b exp 0", flit_out_valid); end
        tick();
        n_tests++;
        if (flit_out_valid !== 1'b1 || flit_out_data !== exp) begin
            n_fail++; $display("FAIL single_flit got %b/%h exp 1/%h", flit_out_valid, flit_out_data, exp);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_tests++;
            if (flit_out_valid !== 1'b0) begin n_fail++; $display("FAIL single_once got %b exp 0", flit_out_valid); end
        end
    endtask

    task automatic test_round_robin();
        logic [FLIT_W-1:0] seen[$];
        logic [SRC_W-1:0]  s;
        do_reset();
        enable         = 1'b1;
        flit_out_ready = 1'b1;
        for (int i = 0; i < N_PE; i++) pe_in_data[i*DW +: DW] = i;
        pe_in_valid = '1;
        tick();
        tick();
        pe_in_valid = '0;
        for (int c = 0; c < 40; c++) begin
            if (flit_out_valid) seen.push_back(flit_out_data);
            tick();
        end
        n_tests++;
        if (seen.size() != 2 * N_PE) begin n_fail++; $display("FAIL rr_count got %0d exp %0d", seen.size(), 2 * N_PE); end
        for (int k = 0; k < seen.size() && k < 2 * N_PE; k++) begin
            s = SRC_W'(k % N_PE);
            n_tests++;
            if (seen[k] !== {s, DW'(k % N_PE)}) begin
                n_fail++; $display("FAIL rr_order[%0d] got %h exp %h", k, seen[k], {s, DW'(k % N_PE)});
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] w [6];
        logic          acc;
        int            k;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            w[i] = $urandom();
            exp_q.push_back({SRC_W'(0), w[i]});
        end
        enable         = 1'b1;
        flit_out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 9; c++) begin
            pe_in_valid[0] = (k < 6);
            pe_in_data[0 +: DW] = w[k < 6 ? k : 5];
            #1;
            acc = pe_in_ready[0] && (k < 6);
            if (flit_out_valid) begin
                n_tests++;
                if (flit_out_data !== exp_q[0]) begin
                    n_fail++; $display("FAIL stall_stable got %h exp %h", flit_out_data, exp_q[0]);
                end
            end
            tick();
            if (acc) k++;
        end
        n_tests++;
        if (k != 5) begin n_fail++; $display("FAIL stall_accepted got %0d exp 5", k); end
        n_tests++;
        if (fifo_full[0] !== 1'b1 || pe_in_ready[0] !== 1'b0) begin
            n_fail++; $display("FAIL stall_full got full=%b ready=%b exp 1/0", fifo_full[0], pe_in_ready[0]);
        end
        n_tests++;
        if (flit_out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid got %b exp 1", flit_out_valid); end
        flit_out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            pe_in_valid[0] = (k < 6);
            pe_in_data[0 +: DW] = w[k < 6 ? k : 5];
            #1;
            acc = pe_in_ready[0] && (k < 6);
            if (flit_out_valid) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL drain_extra got %h exp none", flit_out_data);
                end else if (flit_out_data !== exp_q[0]) begin
                    n_fail++; $display("FAIL drain_order got %h exp %h", flit_out_data, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
            tick();
            if (acc) k++;
        end
        pe_in_valid = '0;
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL drain_left got %0d exp 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_enable_off();
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        a = $urandom();
        b = $urandom();
        do_reset();
        enable         = 1'b1;
        flit_out_ready = 1'b0;
        pe_in_valid[1] = 1'b1;
        pe_in_data[1*DW +: DW] = a;
        tick();
        pe_in_data[1*DW +: DW] = b;
        tick();
        pe_in_valid = '0;
        tick();
        n_tests++;
        if (flit_out_valid !== 1'b1 || flit_out_data !== {SRC_W'(1), a}) begin
            n_fail++; $display("FAIL en_held got %b/%h exp 1/%h", flit_out_valid, flit_out_data, {SRC_W'(1), a});
        end
        enable         = 1'b0;
        flit_out_ready = 1'b1;
        pe_in_valid    = '1;
        #1;
        n_tests++;
        if (pe_in_ready !== '0) begin n_fail++; $display("FAIL en_ready got %b exp 0", pe_in_ready); end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_tests++;
            if (flit_out_valid !== 1'b0 || pe_in_ready !== '0) begin
                n_fail++; $display("FAIL en_off got valid=%b ready=%b exp 0/0", flit_out_valid, pe_in_ready);
            end
        end
        pe_in_valid = '0;
        enable      = 1'b1;
        tick();
        n_tests++;
        if (flit_out_valid !== 1'b1 || flit_out_data !== {SRC_W'(1), b}) begin
            n_fail++; $display("FAIL en_resume got %b/%h exp 1/%h", flit_out_valid, flit_out_data, {SRC_W'(1), b});
        end
        tick();
        n_tests++;
        if (flit_out_valid !== 1'b0) begin n_fail++; $display("FAIL en_drain got %b exp 0", flit_out_valid); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        enable         = 1'b1;
        flit_out_ready = 1'b0;
        pe_in_valid[3] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            pe_in_data[3*DW +: DW] = $urandom();
            tick();
        end
        pe_in_valid = '0;
        reset = 1'b0;
        tick();
        n_tests++;
        if (flit_out_valid !== 1'b0 || flit_out_data !== '0 || fifo_full !== '0) begin
            n_fail++; $display("FAIL midrst got valid=%b data=%h full=%b exp 0/0/0", flit_out_valid, flit_out_data, fifo_full);
        end
        reset          = 1'b1;
        flit_out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_tests++;
            if (flit_out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_discard got %b exp 0", flit_out_valid); end
        end
        pe_in_valid[8] = 1'b1;
        pe_in_valid[0] = 1'b1;
        pe_in_data[8*DW +: DW] = 32'h8888_0008;
        pe_in_data[0 +: DW]    = 32'h0000_0000;
        tick();
        pe_in_valid = '0;
        tick();
        n_tests++;
        if (flit_out_valid !== 1'b1 || flit_out_data[FLIT_W-1 -: SRC_W] !== 4'd0) begin
            n_fail++; $display("FAIL midrst_rr got %b/%h exp src 0", flit_out_valid, flit_out_data);
        end
        tick();
        n_tests++;
        if (flit_out_valid !== 1'b1 || flit_out_data !== {4'd8, 32'h8888_0008}) begin
            n_fail++; $display("FAIL midrst_rr2 got %b/%h exp 1/%h", flit_out_valid, flit_out_data, {4'd8, 32'h8888_0008});
        end
        tick();
    endtask

    task automatic test_random();
        logic [N_PE-1:0] ef;
        logic [N_PE-1:0] er;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N_PE; i++) ef[i] = (mq[i].size() == DEPTH);
            er = {N_PE{reset & enable}} & ~ef;
            n_tests++;
            if (flit_out_valid !== m_valid) begin
                n_fail++; $display("FAIL rnd_valid cyc %0d got %b exp %b", c, flit_out_valid, m_valid);
            end
            if (m_valid) begin
                n_tests++;
                if (flit_out_data !== m_data) begin
                    n_fail++; $display("FAIL rnd_data cyc %0d got %h exp %h", c, flit_out_data, m_data);
                end
            end
            n_tests++;
            if (fifo_full !== ef || pe_in_ready !== er) begin
                n_fail++; $display("FAIL rnd_status cyc %0d got full=%b ready=%b exp %b/%b", c, fifo_full, pe_in_ready, ef, er);
            end
            reset          = ($urandom_range(0, 499) != 0);
            enable         = ($urandom_range(0, 9) != 0);
            flit_out_ready = ($urandom_range(0, 9) < 6);
            for (int i = 0; i < N_PE; i++) begin
                pe_in_valid[i]       = ($urandom_range(0, 3) == 0);
                pe_in_data[i*DW +: DW] = $urandom();
            end
            tick();
        end
        reset       = 1'b1;
        pe_in_valid = '0;
    endtask

`ifdef NOC_PE_INJECT_BRIDGE_STATS_EN
    task automatic test_stats();
        int seen;
        int cyc;
        do_reset();
        stat_sel       = 4'd2;
        enable         = 1'b1;
        flit_out_ready = 1'b1;
        pe_in_valid[2] = 1'b1;
        seen = 0;
        cyc  = 0;
        while (seen < 65540 && cyc < 70000) begin
            pe_in_data[2*DW +: DW] = cyc;
            if (flit_out_valid) begin
                seen++;
                if (seen == 10) begin
                    #1;
                    n_tests++;
                    if (stat_count !== 16'd10) begin n_fail++; $display("FAIL stat_10 got %0d exp 10", stat_count); end
                end
            end
            tick();
            cyc++;
        end
        pe_in_valid = '0;
        n_tests++;
        if (seen < 65540) begin n_fail++; $display("FAIL stat_timeout got %0d exp 65540", seen); end
        #1;
        n_tests++;
        if (stat_count !== 16'hFFFF) begin n_fail++; $display("FAIL stat_sat got %h exp ffff", stat_count); end
        stat_sel = 4'd9;
        #1;
        n_tests++;
        if (stat_count !== 16'h0) begin n_fail++; $display("FAIL stat_oob got %h exp 0", stat_count); end
        stat_sel = 4'd0;
        #1;
        n_tests++;
        if (stat_count !== 16'h0) begin n_fail++; $display("FAIL stat_pe0 got %h exp 0", stat_count); end
    endtask
`endif

    initial begin
        reset          = 1'b0;
        enable         = 1'b0;
        pe_in_data     = '0;
        pe_in_valid    = '0;
        flit_out_ready = 1'b0;
`ifdef NOC_PE_INJECT_BRIDGE_STATS_EN
        stat_sel       = '0;
`endif
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_enable_off();
        test_mid_reset();
        test_random();
`ifdef NOC_PE_INJECT_BRIDGE_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
